// File: rtl/axis_preamble_inserter_pkg.sv
// Shared constants for the preamble inserter and the receiver-side synchronizers:
// sample format, preamble geometry, FSM encoding and the short-symbol table.
package axis_preamble_inserter_pkg;

    localparam int PREAMBLE_DATA_W = 32;
    localparam int PREAMBLE_PERIOD = 25;
    localparam int PREAMBLE_N_REP  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2
    } state_t;

    // One oversampled short symbol, I in [31:16], Q in [15:0], signed 16-bit each.
    localparam logic [31:0] PREAMBLE_TBL [PREAMBLE_PERIOD] = '{
        32'h5A82_5A82, 32'h5A82_A57E, 32'hA57E_A57E, 32'hA57E_5A82, 32'h7FFF_0000,
        32'h0000_7FFF, 32'h8001_0000, 32'h0000_8001, 32'h5A82_5A82, 32'hA57E_5A82,
        32'h2D41_763A, 32'h763A_2D41, 32'hD2BF_89C6, 32'h89C6_D2BF, 32'h5A82_A57E,
        32'hA57E_A57E, 32'h30FB_7641, 32'h7641_30FB, 32'hCF05_89BF, 32'h89BF_CF05,
        32'h5A82_5A82, 32'hA57E_5A82, 32'h18F9_7D8A, 32'h7D8A_18F9, 32'hE707_8276
    };

    // Counter width that stays legal for a one-entry range.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/preamble_rom.sv
// Combinational preamble sample ROM backed by the shared package table.
// Zero latency; addresses past the table return zero.
module preamble_rom
    import axis_preamble_inserter_pkg::*;
#(
    parameter int DATA_W = PREAMBLE_DATA_W,
    parameter int PERIOD = PREAMBLE_PERIOD,
    parameter int IDX_W  = cnt_w(PREAMBLE_PERIOD)
) (
    input  logic [IDX_W-1:0]  addr,
    output logic [DATA_W-1:0] rd_dat
);

    always_comb begin
        rd_dat = '0;
        if (int'(addr) < PERIOD && int'(addr) < PREAMBLE_PERIOD) begin
            rd_dat = DATA_W'(PREAMBLE_TBL[addr]);
        end
    end

endmodule

// File: rtl/axis_preamble_inserter.sv
// Prepends PERIOD x N_REP preamble samples to each AXI-Stream payload frame.
// One output register, 1-cycle latency; stalls hold counters and data so nothing is dropped.
module axis_preamble_inserter
    import axis_preamble_inserter_pkg::*;
#(
    parameter int DATA_W = PREAMBLE_DATA_W,
    parameter int PERIOD = PREAMBLE_PERIOD,
    parameter int N_REP  = PREAMBLE_N_REP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              busy
);

    localparam int IDX_W = cnt_w(PERIOD);
    localparam int REP_W = cnt_w(N_REP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PERIOD - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(N_REP - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DATA_W-1:0] m_axis_tdata_q, m_axis_tdata_d;
    logic              m_axis_tvalid_q, m_axis_tvalid_d;
    logic              m_axis_tlast_q, m_axis_tlast_d;
    logic              m_axis_tuser_q, m_axis_tuser_d;

    logic [DATA_W-1:0] rom_dat;
    logic              advance;
    logic              pre_step;

    preamble_rom #(
        .DATA_W (DATA_W),
        .PERIOD (PERIOD),
        .IDX_W  (IDX_W)
    ) u_rom (
        .addr   (idx_q),
        .rd_dat (rom_dat)
    );

    assign advance = !m_axis_tvalid_q || m_axis_tready;
    // A pending frame in IDLE loads ROM[0] straight away, so back-to-back frames have no gap.
    assign pre_step = (state_q == ST_PREAMBLE) || (state_q == ST_IDLE && s_axis_tvalid);

    assign s_axis_tready = !rst && (state_q == ST_PAYLOAD) && advance;
    assign busy          = !rst && (state_q != ST_IDLE);

    assign m_axis_tdata  = m_axis_tdata_q;
    assign m_axis_tvalid = m_axis_tvalid_q;
    assign m_axis_tlast  = m_axis_tlast_q;
    assign m_axis_tuser  = m_axis_tuser_q;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        rep_d           = rep_q;
        m_axis_tdata_d  = m_axis_tdata_q;
        m_axis_tvalid_d = m_axis_tvalid_q;
        m_axis_tlast_d  = m_axis_tlast_q;
        m_axis_tuser_d  = m_axis_tuser_q;

        if (state_q == ST_IDLE && s_axis_tvalid) begin
            state_d = ST_PREAMBLE;
        end

        if (advance) begin
            if (pre_step) begin
                m_axis_tdata_d  = rom_dat;
                m_axis_tvalid_d = 1'b1;
                m_axis_tlast_d  = 1'b0;
                m_axis_tuser_d  = (idx_q == '0) && (rep_q == '0);
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (rep_q == REP_LAST) begin
                        rep_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else if (state_q == ST_PAYLOAD) begin
                // Missing input leaves a bubble rather than fill data.
                m_axis_tvalid_d = s_axis_tvalid;
                m_axis_tlast_d  = s_axis_tvalid && s_axis_tlast;
                m_axis_tuser_d  = 1'b0;
                if (s_axis_tvalid) begin
                    m_axis_tdata_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end else begin
                m_axis_tvalid_d = 1'b0;
                m_axis_tlast_d  = 1'b0;
                m_axis_tuser_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            rep_q           <= '0;
            m_axis_tdata_q  <= '0;
            m_axis_tvalid_q <= 1'b0;
            m_axis_tlast_q  <= 1'b0;
            m_axis_tuser_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            rep_q           <= rep_d;
            m_axis_tdata_q  <= m_axis_tdata_d;
            m_axis_tvalid_q <= m_axis_tvalid_d;
            m_axis_tlast_q  <= m_axis_tlast_d;
            m_axis_tuser_q  <= m_axis_tuser_d;
        end
    end

endmodule

// File: tb/tb_axis_preamble_inserter.sv
// Directed bench for axis_preamble_inserter: full frames, backpressure, back-to-back,
// input bubbles, mid-preamble reset and single-sample payloads.
module tb_axis_preamble_inserter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;

    axis_preamble_inserter dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] rom_t [25] = '{
        32'h5A82_5A82, 32'h5A82_A57E, 32'hA57E_A57E, 32'hA57E_5A82, 32'h7FFF_0000,
        32'h0000_7FFF, 32'h8001_0000, 32'h0000_8001, 32'h5A82_5A82, 32'hA57E_5A82,
        32'h2D41_763A, 32'h763A_2D41, 32'hD2BF_89C6, 32'h89C6_D2BF, 32'h5A82_A57E,
        32'hA57E_A57E, 32'h30FB_7641, 32'h7641_30FB, 32'hCF05_89BF, 32'h89BF_CF05,
        32'h5A82_5A82, 32'hA57E_5A82, 32'h18F9_7D8A, 32'h7D8A_18F9, 32'hE707_8276
    };

    int total = 0;
    int bad   = 0;

    logic [33:0] got_q [$];   // {tuser, tlast, tdata}
    logic [33:0] exp_q [$];
    logic [32:0] src_q [$];   // {tlast, tdata}
    int          last_cycs [$];
    int          user_cycs [$];
    logic        busy_at_last [$];
    logic        prev_busy_at_last [$];

    int          cyc_cnt   = 0;
    int          gap_cnt   = 0;
    int          stall_obs = 0;
    int          stall_viol = 0;
    logic        bp_en = 1'b0;
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_busy = 1'b0;
    logic [33:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            prev_vld  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                stall_obs++;
                if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_beat)
                    stall_viol++;
            end
            if (busy && !m_axis_tvalid) gap_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
                if (m_axis_tlast) begin
                    last_cycs.push_back(cyc_cnt);
                    busy_at_last.push_back(busy);
                    prev_busy_at_last.push_back(prev_busy);
                end
                if (m_axis_tuser) user_cycs.push_back(cyc_cnt);
            end
            prev_vld  = m_axis_tvalid;
            prev_rdy  = m_axis_tready;
            prev_busy = busy;
            prev_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [31:0] pay(input int k, input int salt);
        return {8'(salt), 8'h5A, 16'(k * 257 + 1)};
    endfunction

    task automatic clear_all();
        got_q.delete(); exp_q.delete(); src_q.delete();
        last_cycs.delete(); user_cycs.delete();
        busy_at_last.delete(); prev_busy_at_last.delete();
        gap_cnt = 0; stall_obs = 0; stall_viol = 0;
    endtask

    task automatic push_pre();
        for (int k = 0; k < 400; k++)
            exp_q.push_back({(k == 0), 1'b0, rom_t[k % 25]});
    endtask

    task automatic push_pay(input logic [31:0] d, input logic last);
        exp_q.push_back({1'b0, last, d});
        src_q.push_back({last, d});
    endtask

    task automatic add_frame(input int n, input int salt);
        push_pre();
        for (int k = 0; k < n; k++) push_pay(pay(k, salt), (k == n - 1));
    endtask

    task automatic run_src(input int bub_at, input int bub_len);
        int   sent = 0;
        int   left = bub_len;
        int   cyc  = 0;
        logic acc;
        while (src_q.size() > 0 && cyc < 20000) begin
            cyc++;
            if (sent == bub_at && left > 0) begin
                s_axis_tvalid = 1'b0;
                left--;
                @(posedge clk);
                #1;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0][31:0];
                s_axis_tlast  = src_q[0][32];
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                if (acc) begin
                    void'(src_q.pop_front());
                    sent++;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("src_drained", src_q.size(), 0);
    endtask

    task automatic wait_and_compare(input string tag);
        int c = 0;
        while (got_q.size() < exp_q.size() && c < 4000) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int diff;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata",  m_axis_tdata, 0);
        chk("rst_tuser",  m_axis_tuser, 0);
        chk("rst_tlast",  m_axis_tlast, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_sready", s_axis_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Plain 10-sample frame, no stall.
        clear_all();
        add_frame(10, 1);
        run_src(-1, 0);
        wait_and_compare("nostall");

        // Same frame under random 50% backpressure.
        clear_all();
        bp_en = 1'b1;
        add_frame(10, 2);
        run_src(-1, 0);
        wait_and_compare("bp");
        bp_en = 1'b0;
        chk("bp_hold_viol", stall_viol, 0);
        chk("bp_stalls_seen", (stall_obs > 20), 1);
        @(posedge clk);
        #1;

        // Back-to-back frames A (3 samples) and B (1 sample).
        clear_all();
        add_frame(3, 3);
        add_frame(1, 4);
        run_src(-1, 0);
        wait_and_compare("b2b");
        diff = (user_cycs.size() == 2 && last_cycs.size() == 2) ? user_cycs[1] - last_cycs[0] : -1;
        chk("b2b_tuser_gap", diff, 1);

        // Input bubble of 5 cycles after 5 payload samples.
        clear_all();
        add_frame(10, 5);
        run_src(5, 5);
        wait_and_compare("bubble");
        chk("bubble_gap", gap_cnt, 5);

        // Reset at preamble sample 137.
        clear_all();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b0;
        for (int c = 0; c < 1000 && got_q.size() < 137; c++) @(negedge clk);
        chk("pre_rst_beats", got_q.size(), 137);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("in_rst_busy",   busy, 0);
        chk("in_rst_sready", s_axis_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tvalid", m_axis_tvalid, 0);
        chk("post_rst_tdata",  m_axis_tdata, 0);
        chk("post_rst_tuser",  m_axis_tuser, 0);
        chk("post_rst_tlast",  m_axis_tlast, 0);
        chk("post_rst_busy",   busy, 0);
        chk("rst_no_tlast", last_cycs.size(), 0);
        @(posedge clk);
        #1;
        clear_all();
        add_frame(4, 6);
        run_src(-1, 0);
        wait_and_compare("after_rst");

        // Single-sample payload.
        clear_all();
        push_pre();
        push_pay(32'h7FFF_8000, 1'b1);
        run_src(-1, 0);
        wait_and_compare("single");
        chk("single_busy_at_last", (busy_at_last.size() == 1) ? busy_at_last[0] : 1'bx, 0);
        chk("single_busy_before",  (prev_busy_at_last.size() == 1) ? prev_busy_at_last[0] : 1'bx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_preamble_inserter.md
AXIS_PREAMBLE_INSERTER -- requirements
Module: axis_preamble_inserter

Interface
REQ-001 Parameter DATA_W, default 32, shall be the sample width: I in [31:16], Q in [15:0], each signed 16-bit.
REQ-002 Parameter PERIOD, default 25, shall be the samples per preamble repetition (one short symbol × oversampling factor 25).
REQ-003 Parameter N_REP, default 16, shall be the preamble repetitions per frame, giving a total of PERIOD×N_REP = 400 samples.
REQ-004 Port clk, input, 1 bit, shall be the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit, shall be the reset; it is synchronous and active-high.
REQ-006 Port s_axis_tdata, input, DATA_W bits, shall carry the payload sample.
REQ-007 Port s_axis_tvalid, input, 1 bit, shall indicate that a valid payload sample is present.
REQ-008 Port s_axis_tlast, input, 1 bit, shall mark the last payload sample of a frame.
REQ-009 Port s_axis_tready, output, 1 bit, shall indicate that the block accepts a payload sample.
REQ-010 Port m_axis_tdata, output, DATA_W bits, shall carry the preamble or payload sample.
REQ-011 Port m_axis_tvalid, output, 1 bit, shall indicate that the output sample is valid.
REQ-012 Port m_axis_tready, input, 1 bit, shall indicate downstream acceptance.
REQ-013 Port m_axis_tlast, output, 1 bit, shall be high on the final payload sample of a frame only.
REQ-014 Port m_axis_tuser, output, 1 bit, shall be high on the first preamble sample of a frame only.
REQ-015 Port busy, output, 1 bit, shall be high whenever the FSM is not in IDLE.

Function
REQ-016 The output stage shall be a single register; "advance" is defined as (!m_axis_tvalid || m_axis_tready), and the output register loads only on advance.
REQ-017 The FSM shall have three states, IDLE, PREAMBLE and PAYLOAD, with the following transitions:
- IDLE -> PREAMBLE when s_axis_tvalid is high; no payload sample is consumed in IDLE.
- PREAMBLE -> PAYLOAD after the 400th preamble sample is loaded.
- PAYLOAD -> IDLE after the sample with s_axis_tlast is accepted.
REQ-018 In PREAMBLE, each advance shall load ROM[idx] into the output register. idx counts 0..PERIOD-1 and wraps to 0; rep increments on each wrap and counts 0..N_REP-1.
REQ-019 When advance is low, the counters and output register shall hold, so no preamble sample is dropped or repeated under backpressure.
REQ-020 m_axis_tuser shall be loaded as 1 only when idx=0 and rep=0, and as 0 otherwise.
REQ-021 Preamble samples shall never carry m_axis_tlast=1.
REQ-022 s_axis_tready shall equal (state==PAYLOAD && advance), combinationally.
REQ-023 In all other states s_axis_tready shall be 0.
REQ-024 A payload transfer shall load tdata and tlast unchanged, with tuser=0.
REQ-025 Latency shall be 1 cycle from an accepted input, or from a ROM read, to m_axis_tvalid.
REQ-026 In PAYLOAD with s_axis_tvalid low and advance high, m_axis_tvalid shall be loaded 0, forming a bubble with no fill data.
REQ-027 A single-sample payload (tlast on the first sample) shall be legal and shall return the FSM to IDLE.
REQ-028 Back-to-back frames: the cycle after the tlast transfer the FSM is in IDLE, and a pending s_axis_tvalid shall start a new preamble without a gap cycle.
REQ-029 There shall be no payload-length limit; the counters are inactive in PAYLOAD.
REQ-030 The ROM shall be read combinationally, indexed by idx.

Reset
REQ-031 While rst is high at a clock edge, the block shall set state=IDLE, idx=0 and rep=0, and clear m_axis_tvalid, m_axis_tdata, m_axis_tlast and m_axis_tuser.
REQ-032 During reset, s_axis_tready=0 and busy=0.
REQ-033 A reset mid-frame shall abandon the frame without emitting tlast; the next frame shall start with a full 400-sample preamble.

Structure
REQ-034 A shared package shall hold DATA_W, PERIOD, N_REP, the state encoding, and the 25-entry preamble constant table; receiver-side synchronizer blocks use the same table.
REQ-035 The ROM shall be the sub-module preamble_rom: PERIOD×DATA_W entries, combinational read, contents taken from the package table.
REQ-036 idx shall be ceil(log2(PERIOD)) bits wide and rep shall be ceil(log2(N_REP)) bits wide.

Verification
REQ-037 Frame, no stall: drive 10 payload samples, tlast on the 10th, with m_axis_tready=1.
- Required response: 410 beats; beats 0..399 equal ROM[k mod 25]; tuser only on beat 0; beats 400..409 equal the input; tlast only on beat 409.
REQ-038 Random backpressure: drive m_axis_tready with a 50% random pattern over a 400-sample preamble.
- Required response: the sequence is identical to REQ-037, with no drops or duplicates and tdata stable while tvalid && !tready.
REQ-039 Back-to-back frames: drive frame A (3 samples) and frame B (1 sample) continuously.
- Required response: 403 beats, then 401 beats; frame B's tuser occurs the cycle after A's tlast beat is accepted.
REQ-040 Input bubbles: drop s_axis_tvalid for 5 cycles in the middle of the payload.
- Required response: m_axis_tvalid is low for 5 cycles and the payload order is preserved.
REQ-041 Reset at preamble sample 137: assert rst for 1 cycle.
- Required response: outputs are 0 the next cycle; the next frame emits a fresh 400-sample preamble starting at ROM[0] with tuser=1.
REQ-042 Single-sample payload, 0x7FFF8000 with tlast: the 401st beat equals 0x7FFF8000 with tlast=1, and busy falls the next cycle.
